// File: rtl/rx_pattern_gen_if.sv
// Receive-path sample and settings-bus bundle between rx_chain, the pattern gate and rx_buffer.
// Combinational wiring only; no backpressure, samples are qualified by strobes alone.
interface rx_pattern_gen_if #(
  parameter int NCHAN = 2,
  parameter int WIDTH = 16
);
  logic                     enable;
  logic                     strobe_in;
  logic [NCHAN*WIDTH-1:0]   data_in;
  logic [6:0]               serial_addr;
  logic [31:0]              serial_data;
  logic                     serial_strobe;
  logic [NCHAN*WIDTH-1:0]   data_out;
  logic                     strobe_out;
  logic                     burst_done;

  modport master (
    output enable, strobe_in, data_in, serial_addr, serial_data, serial_strobe,
    input  data_out, strobe_out, burst_done
  );

  modport slave (
    input  enable, strobe_in, data_in, serial_addr, serial_data, serial_strobe,
    output data_out, strobe_out, burst_done
  );
endinterface

// File: rtl/rx_pattern_gen.sv
// Receive test-pattern source/gate: passthrough, counter, per-channel PRBS15 or constant, with burst limit.
// One-cycle latency from strobe_in; no backpressure, strobes beyond the burst limit are dropped.
module rx_pattern_gen #(
  parameter int         NCHAN     = 2,
  parameter int         WIDTH     = 16,
  parameter logic [6:0] BASE_ADDR = 7'd40
) (
  input  logic                clock,
  input  logic                reset_n,
  rx_pattern_gen_if.slave     bus
);
  localparam int DW = NCHAN * WIDTH;
  localparam int PW = (WIDTH < 15) ? WIDTH : 15;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CNT   = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [15:0]       burst_q, burst_d;
  logic [WIDTH-1:0]  const_q, const_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [14:0]       lfsr_q [NCHAN];
  logic [14:0]       lfsr_d [NCHAN];
  logic [15:0]       bcnt_q, bcnt_d;
  logic              done_q, done_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              sout_q, sout_d;

  logic              wr_mode, wr_burst, wr_const, wr_any, emit;
  logic [DW-1:0]     sample;
  logic [16:0]       bcnt_inc;

  function automatic logic [WIDTH-1:0] prbs_word(input logic [14:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < PW; i++) r[i] = s[i];
    return r;
  endfunction

  assign wr_mode  = bus.serial_strobe && (bus.serial_addr == BASE_ADDR);
  assign wr_burst = bus.serial_strobe && (bus.serial_addr == BASE_ADDR + 7'd1);
  assign wr_const = bus.serial_strobe && (bus.serial_addr == BASE_ADDR + 7'd2);
  assign wr_any   = wr_mode || wr_burst || wr_const;
  assign emit     = bus.enable && bus.strobe_in && !done_q;
  assign bcnt_inc = {1'b0, bcnt_q} + 17'd1;

  // Output word is built only from pre-edge state, so a write never mixes modes in one sample.
  always_comb begin
    sample = '0;
    for (int k = 0; k < NCHAN; k++) begin
      case (mode_q)
        MODE_PASS: sample[k*WIDTH +: WIDTH] = bus.data_in[k*WIDTH +: WIDTH];
        MODE_CNT:  sample[k*WIDTH +: WIDTH] = cnt_q + WIDTH'(k);
        MODE_PRBS: sample[k*WIDTH +: WIDTH] = prbs_word(lfsr_q[k]);
        default:   sample[k*WIDTH +: WIDTH] = const_q + WIDTH'(k);
      endcase
    end
  end

  always_comb begin
    mode_d  = mode_q;
    burst_d = burst_q;
    const_d = const_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    bcnt_d  = bcnt_q;
    done_d  = done_q;
    sout_d  = emit;
    dout_d  = emit ? sample : dout_q;

    if (wr_mode)  mode_d  = mode_e'(bus.serial_data[1:0]);
    if (wr_burst) burst_d = bus.serial_data[15:0];
    if (wr_const) const_d = bus.serial_data[WIDTH-1:0];

    // Clearing beats advancement: the sample still goes out, but the next one restarts.
    if (!bus.enable || wr_any) begin
      cnt_d  = '0;
      for (int k = 0; k < NCHAN; k++) lfsr_d[k] = 15'(k + 1);
      bcnt_d = '0;
      done_d = 1'b0;
    end else if (emit) begin
      cnt_d = cnt_q + WIDTH'(NCHAN);
      for (int k = 0; k < NCHAN; k++)
        lfsr_d[k] = {lfsr_q[k][13:0], lfsr_q[k][14] ^ lfsr_q[k][13]};
      if (burst_q != 16'd0) begin
        if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
        if (bcnt_inc >= {1'b0, burst_q}) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_PASS;
      burst_q <= '0;
      const_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NCHAN; k++) lfsr_q[k] <= 15'(k + 1);
      bcnt_q  <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      sout_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      burst_q <= burst_d;
      const_q <= const_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.strobe_out = sout_q;
  assign bus.burst_done = done_q;
endmodule

// File: doc/rx_pattern_gen.md
Name: rx_pattern_gen

Overview:
Parametrised receive-path test-pattern source and gate that sits between the rx_chain outputs and rx_buffer, replacing the fixed two-channel debug counter. It supports NCHAN channels of WIDTH bits each, selected through a serial-bus mode register. Modes are: passthrough, interleaved counter, per-channel PRBS15 and per-channel constant. An optional burst limit stops output after a programmed number of sample strobes.

Parameters:
NCHAN, 2, number of channels; 1..8
WIDTH, 16, bits per channel sample; 8..32
BASE_ADDR, 7'd40, serial address of MODE register; BURST register is BASE_ADDR+1, CONST register is BASE_ADDR+2

Ports:
clock  in  1  sample-domain clock (adcclk)
reset_n  in  1  asynchronous, active-low reset
enable  in  1  receive enable; low clears generator state and burst state
strobe_in  in  1  sample strobe (hb_strobe)
data_in  in  NCHAN*WIDTH  real samples; channel k is data_in[k*WIDTH +: WIDTH]
serial_addr  in  7  settings bus address
serial_data  in  32  settings bus data
serial_strobe  in  1  settings bus write strobe
data_out  out  NCHAN*WIDTH  registered output samples
strobe_out  out  1  registered sample strobe
burst_done  out  1  high once the burst limit is reached

Behaviour:
- reset_n low (asynchronous): data_out=0, strobe_out=0, burst_done=0. MODE=0, BURST=0, CONST=0, counter=0, LFSR[k]=k+1, burst count=0.
- Register writes: take effect when serial_strobe=1 and serial_addr matches.
  - MODE[1:0]: 0 passthrough, 1 counter, 2 PRBS, 3 constant.
  - BURST[15:0]: strobe limit; 0 means unlimited.
  - CONST[31:0]: constant value, truncated to WIDTH.
- Any register write also clears the counter, reseeds the LFSRs, clears the burst count and clears burst_done, all on the next clock edge.
- Latency: exactly 1 cycle. When strobe_in=1, enable=1 and the burst limit is not reached, data_out and strobe_out load on the next edge. Otherwise strobe_out=0 and data_out holds its value.
- Passthrough: channel k output = data_in channel k.
- Counter:
  - Channel k output = (cnt + k) mod 2^WIDTH.
  - cnt advances by NCHAN per emitted strobe and wraps mod 2^WIDTH.
  - NCHAN=2 reproduces the legacy i/q counter pair.
- PRBS:
  - Each channel has its own 15-bit Fibonacci LFSR, polynomial x^15+x^14+1, seed k+1.
  - Output = LFSR value zero-extended to WIDTH (truncated to the low WIDTH bits when WIDTH<15).
  - The LFSR steps once per emitted strobe; the emitted value is the pre-step state.
  - The all-zero state is unreachable.
- Constant: channel k output = (CONST + k) mod 2^WIDTH.
- Burst:
  - When BURST≠0, the burst count increments per emitted strobe.
  - When count reaches BURST, burst_done goes high on that same edge and later strobes are suppressed.
  - burst_done holds until enable goes low or a register is written.
  - Burst count saturates; it does not wrap.
- enable low:
  - strobe_out=0 on the next edge.
  - Counter cleared, LFSRs reseeded, burst count and burst_done cleared.
  - Registers retained.
- Register write and strobe_in in the same cycle: that sample is emitted using the pre-write mode and state. The write then takes priority over advancement, so the next sample starts from the cleared/reseeded state in the new mode.
- enable falling in the same cycle as strobe_in: the sample is not emitted.
- Mode changes never produce a partial or mixed-mode output word.

Test Plan:
- Counter: NCHAN=2, WIDTH=16, MODE=1, enable=1, 4 strobes → outputs (0,1), (2,3), (4,5), (6,7), each 1 cycle after its strobe_in; start cnt at 0xFFFE → (0xFFFE,0xFFFF) then (0x0000,0x0001).
- PRBS: NCHAN=4, MODE=2 → first outputs 1, 2, 3, 4; channel 0 sequence 0x0001, 0x0002, 0x0004, …; period 32767 strobes with no zero word.
- Burst: MODE=3, CONST=0x1234, BURST=3, 5 strobes → exactly 3 strobe_out pulses carrying (0x1234, 0x1235); burst_done rises on the 3rd output edge. Deassert enable, then reassert → next 3 strobes emitted again.
- Passthrough with a mid-run write: MODE=0 with a random data_in stream, MODE=1 written in the same cycle as a strobe → that sample equals data_in; the following sample is (0,1).
- Reset: assert reset_n=0 asynchronously mid-burst, between clock edges → data_out, strobe_out and burst_done go to 0 immediately; after release all registers read back 0 and the block runs in passthrough.
- enable=0 with continuous strobe_in → no strobe_out; the first enabled counter sample is (0,1).
